// File: rtl/polyvecl_pointwise_acc_arbiter.sv
// Two-requester arbiter in front of one shared polyvecl pointwise-accumulate unit.
// Define PW_ARB_ROUND_ROBIN_EN for round-robin tie breaking; otherwise requester 0 wins ties.
module polyvecl_pointwise_acc_arbiter #(
  parameter int U_W     = 40960,
  parameter int W_W     = 8192,
  parameter int GAP_CYC = 2
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           rtr0,
  input  logic           rtr1,
  input  logic [U_W-1:0] linear_u0,
  input  logic [U_W-1:0] linear_u1,
  input  logic [U_W-1:0] linear_v0,
  input  logic [U_W-1:0] linear_v1,
  output logic           rts0,
  output logic           rts1,
  output logic [W_W-1:0] linear_w,
  output logic [1:0]     grant,
  output logic           acc_rtr,
  output logic [U_W-1:0] acc_linear_u,
  output logic [U_W-1:0] acc_linear_v,
  input  logic [W_W-1:0] acc_linear_w,
  input  logic           acc_rts
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DONE  = 2'd2,
    GAP   = 2'd3
  } state_t;

  localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_t           state, state_next;
  logic             owner, owner_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture;
  logic             owner_rtr;
`ifdef PW_ARB_ROUND_ROBIN_EN
  logic             prio, prio_next;
`endif

  assign owner_rtr = owner ? rtr1 : rtr0;

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    if (!reset) begin
      state    <= IDLE;
      owner    <= 1'b0;
      cnt      <= '0;
      // NOTE: the result register is reset because its zero value is visible on linear_w.
      linear_w <= '0;
`ifdef PW_ARB_ROUND_ROBIN_EN
      prio     <= 1'b0;
`endif
    end else begin
      state <= state_next;
      owner <= owner_next;
      cnt   <= cnt_next;
      if (capture) linear_w <= acc_linear_w;
`ifdef PW_ARB_ROUND_ROBIN_EN
      prio  <= prio_next;
`endif
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path infers a latch.
    state_next = state;
    owner_next = owner;
    cnt_next   = cnt;
    capture    = 1'b0;
`ifdef PW_ARB_ROUND_ROBIN_EN
    prio_next  = prio;
`endif
    case (state)
      IDLE: begin
        if (rtr0 && rtr1) begin
`ifdef PW_ARB_ROUND_ROBIN_EN
          owner_next = prio;
          prio_next  = ~prio;
`else
          owner_next = 1'b0;
`endif
          state_next = GRANT;
        end else if (rtr0) begin
          owner_next = 1'b0;
          state_next = GRANT;
        end else if (rtr1) begin
          owner_next = 1'b1;
          state_next = GRANT;
        end
      end
      // A requester dropping rtr here is ignored; the unit's result is always captured.
      GRANT: begin
        if (acc_rts) begin
          capture    = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        if (!owner_rtr) begin
          if (GAP_CYC == 0) begin
            state_next = IDLE;
          end else begin
            state_next = GAP;
            cnt_next   = CNT_W'(GAP_CYC - 1);
          end
        end
      end
      GAP: begin
        if (cnt == '0) state_next = IDLE;
        else           cnt_next   = cnt - 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs: decoded from state and owner only.
  always_comb begin
    grant        = 2'b00;
    acc_rtr      = 1'b0;
    rts0         = 1'b0;
    rts1         = 1'b0;
    acc_linear_u = '0;
    acc_linear_v = '0;
    if (state == GRANT || state == DONE) begin
      grant        = owner ? 2'b10 : 2'b01;
      acc_linear_u = owner ? linear_u1 : linear_u0;
      acc_linear_v = owner ? linear_v1 : linear_v0;
    end
    if (state == GRANT) acc_rtr = 1'b1;
    if (state == DONE) begin
      rts0 = ~owner;
      rts1 = owner;
    end
  end

endmodule

// File: tb/tb_polyvecl_pointwise_acc_arbiter.sv
// Scoreboard bench for polyvecl_pointwise_acc_arbiter: random requesters, a stub unit,
// and a timing-rule reference model of grant/ready behaviour.
module tb_polyvecl_pointwise_acc_arbiter;

  localparam int U_W     = 64;
  localparam int W_W     = 32;
  localparam int GAP_CYC = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [1:0]     rtr_drv;
  logic [U_W-1:0] u_op [2];
  logic [U_W-1:0] v_op [2];
  logic [1:0]     rts_bus;
  logic [W_W-1:0] linear_w;
  logic [1:0]     grant;
  logic           acc_rtr;
  logic [U_W-1:0] acc_u, acc_v;
  logic [W_W-1:0] acc_linear_w;
  logic           acc_rts;

  int vectors     = 0;
  int miscompares = 0;
  bit stub_fixed  = 1'b1;

  logic [W_W-1:0] exp_q0[$];
  logic [W_W-1:0] exp_q1[$];

  polyvecl_pointwise_acc_arbiter #(.U_W(U_W), .W_W(W_W), .GAP_CYC(GAP_CYC)) dut (
    .clock        (clock),
    .reset        (reset),
    .rtr0         (rtr_drv[0]),
    .rtr1         (rtr_drv[1]),
    .linear_u0    (u_op[0]),
    .linear_u1    (u_op[1]),
    .linear_v0    (v_op[0]),
    .linear_v1    (v_op[1]),
    .rts0         (rts_bus[0]),
    .rts1         (rts_bus[1]),
    .linear_w     (linear_w),
    .grant        (grant),
    .acc_rtr      (acc_rtr),
    .acc_linear_u (acc_u),
    .acc_linear_v (acc_v),
    .acc_linear_w (acc_linear_w),
    .acc_rts      (acc_rts)
  );

  always #5 clock = ~clock;

  function automatic logic [W_W-1:0] unit_fn(input logic [U_W-1:0] u, input logic [U_W-1:0] v);
    return u[W_W-1:0] + v[W_W-1:0];
  endfunction

  function automatic logic [U_W-1:0] rnd();
    return U_W'({$urandom(), $urandom()});
  endfunction

  function automatic int pick_hold();
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return 1;
      2:       return 2;
      default: return 10;
    endcase
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Stand-in for the shared unit: answers acc_rtr after a latency of 1..6 cycles (5 when fixed).
  initial begin : stub
    int  cnt;
    int  lat;
    bit  fired;
    acc_rts      = 1'b0;
    acc_linear_w = '0;
    cnt = 0; lat = 5; fired = 1'b0;
    forever begin
      @(negedge clock);
      acc_rts = 1'b0;
      if (acc_rtr && !fired) begin
        cnt++;
        if (cnt >= lat) begin
          acc_rts      = 1'b1;
          acc_linear_w = unit_fn(acc_u, acc_v);
          fired        = 1'b1;
        end
      end else if (!acc_rtr) begin
        cnt   = 0;
        fired = 1'b0;
        lat   = stub_fixed ? 5 : int'($urandom_range(1, 6));
      end
    end
  end

  // Reference model, stated as timing rules: who owns the unit, whether its result is
  // pending or being held, and the first edge at which a new grant may be issued.
  int             edge_no = 0;
  int             m_owner = -1;
  bit             m_busy  = 1'b0;
  bit             m_hold  = 1'b0;
  int             free_at = 0;
  bit             m_prio  = 1'b0;
  logic [W_W-1:0] m_w     = '0;
  logic [1:0]     prev_rts = 2'b00;
  logic [1:0]     s_rtr;
  logic           s_ars, s_rst;
  logic [1:0]     exp_grant, exp_rts;

  always @(posedge clock) begin
    s_rtr = rtr_drv; s_ars = acc_rts; s_rst = reset;
    edge_no++;
    if (!s_rst) begin
      m_owner = -1; m_busy = 1'b0; m_hold = 1'b0; m_prio = 1'b0; m_w = '0;
      free_at = edge_no + 1;
    end else if (m_busy) begin
      if (s_ars) begin m_busy = 1'b0; m_hold = 1'b1; end
    end else if (m_hold) begin
      if (!s_rtr[m_owner]) begin
        m_hold  = 1'b0;
        m_owner = -1;
        free_at = edge_no + GAP_CYC + 1;
      end
    end else if (edge_no >= free_at && s_rtr != 2'b00) begin
      if (s_rtr == 2'b11) begin
`ifdef PW_ARB_ROUND_ROBIN_EN
        m_owner = int'(m_prio);
        m_prio  = !m_prio;
`else
        m_owner = 0;
`endif
      end else begin
        m_owner = s_rtr[1] ? 1 : 0;
      end
      m_busy = 1'b1;
    end
    #1;
    exp_grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
    exp_rts   = m_hold ? exp_grant : 2'b00;
    check("grant/acc_rtr/rts", {grant, acc_rtr, rts_bus}, {exp_grant, m_busy, exp_rts});
    for (int i = 0; i < 2; i++) begin
      if (rts_bus[i] && !prev_rts[i]) begin
        if (i == 0 && exp_q0.size() > 0)      m_w = exp_q0.pop_front();
        else if (i == 1 && exp_q1.size() > 0) m_w = exp_q1.pop_front();
        else check($sformatf("rts%0d with no pending request", i), 1, 0);
      end
    end
    check("linear_w", linear_w, m_w);
    if (m_busy) begin
      check("acc_linear_u", acc_u, u_op[m_owner]);
      check("acc_linear_v", acc_v, v_op[m_owner]);
    end else if (m_owner < 0) begin
      check("acc operands idle", {acc_u, acc_v}, '0);
    end
    prev_rts = rts_bus;
  end

  task automatic push_exp(input int r, input logic [W_W-1:0] val);
    if (r == 0) exp_q0.push_back(val);
    else        exp_q1.push_back(val);
  endtask

  task automatic wait_rts(input int r);
    int waited = 0;
    while (!rts_bus[r] && waited < 200) begin @(negedge clock); waited++; end
    if (!rts_bus[r]) check($sformatf("rts%0d timeout", r), 0, 1);
  endtask

  // One transaction: present operands, request, optionally drop early, hold after rts, release.
  task automatic do_req(input int r, input int hold, input bit early,
                        input logic [U_W-1:0] u, input logic [U_W-1:0] v);
    int waited = 0;
    @(negedge clock);
    u_op[r] = u;
    v_op[r] = v;
    push_exp(r, unit_fn(u, v));
    rtr_drv[r] = 1'b1;
    if (early) begin
      while (!grant[r] && waited < 200) begin @(negedge clock); waited++; end
      rtr_drv[r] = 1'b0;
    end
    wait_rts(r);
    repeat (hold) @(negedge clock);
    rtr_drv[r] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rtr_drv = 2'b00;
    u_op[0] = '0; u_op[1] = '0; v_op[0] = '0; v_op[1] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;

    // Single request with 0x1234 result, held 10 cycles after rts while requester 1 waits.
    fork
      do_req(0, 10, 1'b0, U_W'(16'h1234), '0);
      begin repeat (3) @(negedge clock); do_req(1, 1, 1'b0, rnd(), rnd()); end
    join
    stub_fixed = 1'b0;

    // Simultaneous requests, twice, then requester 0 alone.
    repeat (2) fork
      do_req(0, 0, 1'b0, rnd(), rnd());
      do_req(1, 0, 1'b0, rnd(), rnd());
    join
    do_req(0, 0, 1'b0, rnd(), rnd());

    // Randomised traffic with early drops and held requests.
    fork
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
        do_req(0, pick_hold(), ($urandom_range(0, 4) == 0), rnd(), rnd());
      end
      for (int k = 0; k < 25; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge clock);
        do_req(1, pick_hold(), ($urandom_range(0, 4) == 0), rnd(), rnd());
      end
    join

    // Reset while the unit is granted.
    stub_fixed = 1'b1;
    repeat (4) @(negedge clock);
    u_op[0] = rnd(); v_op[0] = rnd();
    push_exp(0, unit_fn(u_op[0], v_op[0]));
    rtr_drv[0] = 1'b1;
    begin
      int waited = 0;
      while (!grant[0] && waited < 50) begin @(negedge clock); waited++; end
    end
    check("grant before reset", grant, 2'b01);
    reset = 1'b0;
    @(negedge clock);
    check("grant after reset", grant, 2'b00);
    check("acc_rtr after reset", acc_rtr, 1'b0);
    check("linear_w after reset", linear_w, '0);
    reset      = 1'b1;
    rtr_drv[0] = 1'b0;
    exp_q0.delete();
    stub_fixed = 1'b0;

    // After reset the tie pointer is back at requester 0.
    fork
      do_req(0, 0, 1'b0, rnd(), rnd());
      do_req(1, 0, 1'b0, rnd(), rnd());
    join
    repeat (10) @(negedge clock);
    check("pending results left", exp_q0.size() + exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/polyvecl_pointwise_acc_arbiter.md
# polyvecl_pointwise_acc_arbiter

Shares one `polyvecl_pointwise_acc_montgomery` instance between two requesters, for example the key-generation matrix-vector product and a second polynomial-vector consumer.
- Grants the unit to one requester at a time and muxes that requester's operands into the unit.
- Captures the accumulated result and returns it through the codebase's rtr/rts handshake.
- Enforces the unit's re-arm gap between operations.

## Interface
Parameters:
- `U_W`, 40960: width of each operand vector (`linear_u`, `linear_v`).
- `W_W`, 8192: width of the result polynomial.
- `GAP_CYC`, 2: idle cycles held with `acc_rtr` low after a release, before the next grant.

Ports:
- `clock`  in  1  sole clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset; sampled low on a `clock` edge, it resets the block.
- `rtr0`, `rtr1`  in  1  request from requester 0/1; held high until its `rts` is seen.
- `linear_u0`, `linear_u1`  in  `U_W`  requester 0/1 `u` operand; stable while its `rtr` is high.
- `linear_v0`, `linear_v1`  in  `U_W`  requester 0/1 `v` operand; same stability rule.
- `rts0`, `rts1`  out  1  result ready for requester 0/1.
- `linear_w`  out  `W_W`  registered result; valid while either `rts` is high.
- `grant`  out  2  one-hot current owner; 0 when no owner.
- `acc_rtr`  out  1  request to the shared unit.
- `acc_linear_u`, `acc_linear_v`  out  `U_W`  operands of the granted requester; all-zero when no owner.
- `acc_linear_w`  in  `W_W`  result from the unit.
- `acc_rts`  in  1  unit done.

## Operation
States: IDLE=0, GRANT=1, DONE=2, GAP=3. Outputs are decoded from state and the owner register only (Moore).
- **IDLE**
  - Only `rtr0` high: owner becomes 0, next state GRANT.
  - Only `rtr1` high: owner becomes 1, next state GRANT.
  - Both high: owner becomes `prio`; `prio` then toggles to the other requester.
  - Neither high: stay in IDLE.
- **GRANT**
  - Drive `acc_rtr`=1; `acc_linear_u`/`acc_linear_v` carry the owner's operands.
  - On an edge with `acc_rts`=1: register `linear_w` ← `acc_linear_w`, go to DONE.
  - The owner dropping `rtr` while in GRANT is ignored. No abort: the result is still captured.
- **DONE**
  - `acc_rtr`=0; `rts` of the owner =1; `grant` still shows the owner.
  - When the owner's `rtr` is sampled low, go to GAP. If it is already low on entry, DONE lasts exactly one cycle.
- **GAP**
  - `acc_rtr`=0, `grant`=0, no `rts` high.
  - A counter runs from `GAP_CYC`−1 down to 0; at 0, go to IDLE.
  - Requests are not evaluated in GAP.
- The non-owner's `rtr` is never acknowledged while another owner holds the grant; that request waits in IDLE arbitration.
- `linear_w` keeps its last value until the next capture.

## Timing
- Reset values:
  - state IDLE, owner cleared, `prio`=0, gap counter 0.
  - `grant`=0, `acc_rtr`=0, `rts0`=`rts1`=0.
  - `linear_w`=0, `acc_linear_u`=`acc_linear_v`=0.
- Reset low mid-operation, in any state: all of the above apply on that edge. The shared unit must see the same reset so that it also returns to idle.
- `rtr0` is first sampled high at edge n (state IDLE): `grant`=01 and `acc_rtr`=1 from edge n onward.
- `acc_rts` is sampled high at edge m: `linear_w` and `rts0`=1 are valid from edge m.
- Release: the owner's `rtr` is sampled low at edge p.
  - `rts` falls at edge p.
  - The earliest next grant is at edge p+`GAP_CYC`+1.
- Minimum overhead per transaction is 1 cycle of arbitration, 1 cycle of DONE, and `GAP_CYC` cycles of GAP, plus the unit's own latency.

## Configuration
Macro `PW_ARB_ROUND_ROBIN_EN`:
- **Defined:** tie breaking uses the `prio` pointer, which toggles after every contested grant. Uncontested grants do not change `prio`.
- **Undefined:** fixed priority; requester 0 always wins a tie. `prio` is not implemented.

## Test plan
- **Single requester:** `rtr0`=1 with the unit stubbed to assert `acc_rts` 5 cycles after `acc_rtr` and return 0x1234 in the low bits. Required:
  - `grant`=01.
  - `acc_linear_u` equals `linear_u0`.
  - `rts0`=1 with `linear_w[15:0]`=0x1234.
  - `rts1` stays 0.
- **Simultaneous requests:** `rtr0`=`rtr1`=1 from reset.
  - With the macro defined: requester 0 is served, then requester 1, then requester 0 again on re-request.
  - With the macro undefined: requester 0 always wins.
- **Re-arm gap:** release `rtr0` at edge p while `rtr1` is pending → `grant`=10 no earlier than edge p+3 (`GAP_CYC`=2), and `acc_rtr` is low for cycles p through p+2.
- **Held request:** the owner keeps `rtr`=1 for 10 cycles after `rts` → the block stays in DONE, `rts` stays high, `acc_rtr` stays 0, and the other requester is not granted.
- **Reset mid-operation:** `reset`=0 during GRANT → the next cycle shows `grant`=0, `acc_rtr`=0, `linear_w`=0, and `prio`=0. A new request after reset is served normally.
- **Early drop:** the owner drops `rtr` in GRANT before `acc_rts` → the result is still captured, DONE lasts 1 cycle with `rts` high, then GAP follows.
